// File: rtl/alu_pipe_mem_store.sv
// -----------------------------------------------------------------------------
// alu_pipe_mem_store
// Four-stage pipelined ALU with an internal register file, one forwarding path
// and a data-memory store stage, all on one clock.
//   S1 issue     : latch the instruction fields
//   S2 execute   : read operands (with forwarding), compute, latch result
//   S3 writeback : write the register file, drive zout/out_valid/out_err
//   S4 store     : write data memory with the S3 result
//
// Ports
//   clk        in   single clock, posedge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   instruction present (always accepted)
//   opr        in   opcode [3:0]
//   s1, s2     in   source register indices A, B
//   rd         in   destination register
//   maddr      in   store address
//   imm        in   immediate for LDI
//   wr_en      in   write result to rd
//   st_en      in   store result to memory[maddr]
//   zout       out  result of the retiring instruction
//   out_valid  out  one-cycle pulse per retired instruction
//   out_err    out  retiring instruction had an illegal opcode
//   dbg_raddr  in   memory read-back address
//   dbg_rdata  out  memory[dbg_raddr], one cycle later
// -----------------------------------------------------------------------------
module alu_pipe_mem_store #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4,
  parameter int MA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        opr,
  input  logic [RA_W-1:0]   s1,
  input  logic [RA_W-1:0]   s2,
  input  logic [RA_W-1:0]   rd,
  input  logic [MA_W-1:0]   maddr,
  input  logic [DATA_W-1:0] imm,
  input  logic              wr_en,
  input  logic              st_en,
  output logic [DATA_W-1:0] zout,
  output logic              out_valid,
  output logic              out_err,
  input  logic [MA_W-1:0]   dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int NREG = 2 ** RA_W;
  localparam int NMEM = 2 ** MA_W;

  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_PA   = 4'b0011;
  localparam logic [3:0] OP_PB   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NEGA = 4'b1000;
  localparam logic [3:0] OP_NEGB = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_LDI  = 4'b1101;

  // S1 (issue) latch
  logic              r_s1_valid;
  logic [3:0]        r_s1_opr;
  logic [RA_W-1:0]   r_s1_a;
  logic [RA_W-1:0]   r_s1_b;
  logic [RA_W-1:0]   r_s1_rd;
  logic [MA_W-1:0]   r_s1_maddr;
  logic [DATA_W-1:0] r_s1_imm;
  logic              r_s1_wr;
  logic              r_s1_st;

  // S3-bound latch (result of execute)
  logic              r_ex_valid;
  logic [RA_W-1:0]   r_ex_rd;
  logic [MA_W-1:0]   r_ex_maddr;
  logic [DATA_W-1:0] r_ex_result;
  logic              r_ex_err;
  logic              r_ex_wr;
  logic              r_ex_st;

  // S4 (store) latch
  logic              r_st_valid;
  logic [MA_W-1:0]   r_st_addr;
  logic [DATA_W-1:0] r_st_data;

  // Outputs
  logic [DATA_W-1:0] r_zout;
  logic              r_out_valid;
  logic              r_out_err;
  logic [DATA_W-1:0] r_dbg_rdata;

  // Storage
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_mem  [NMEM];

  // Execute-stage wires
  logic              w_fwd_ok;
  logic              w_wb_en;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_result;
  logic              w_err;

  // The instruction one ahead can forward only if it will actually write.
  assign w_fwd_ok = r_ex_valid && r_ex_wr && !r_ex_err;
  assign w_wb_en  = w_fwd_ok;

  // S1: capture the incoming instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_opr   <= 4'b0000;
      r_s1_a     <= {RA_W{1'b0}};
      r_s1_b     <= {RA_W{1'b0}};
      r_s1_rd    <= {RA_W{1'b0}};
      r_s1_maddr <= {MA_W{1'b0}};
      r_s1_imm   <= ZERO;
      r_s1_wr    <= 1'b0;
      r_s1_st    <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_opr   <= opr;
        r_s1_a     <= s1;
        r_s1_b     <= s2;
        r_s1_rd    <= rd;
        r_s1_maddr <= maddr;
        r_s1_imm   <= imm;
        r_s1_wr    <= wr_en;
        r_s1_st    <= st_en;
      end
    end
  end

  // S2: operand selection; writes two or more instructions back have already
  // landed in the register file, so only the S3-bound latch needs a bypass.
  always_comb begin
    w_a = r_regs[r_s1_a];
    w_b = r_regs[r_s1_b];
    if (w_fwd_ok && (r_ex_rd == r_s1_a)) begin
      w_a = r_ex_result;
    end else begin
      w_a = r_regs[r_s1_a];
    end
    if (w_fwd_ok && (r_ex_rd == r_s1_b)) begin
      w_b = r_ex_result;
    end else begin
      w_b = r_regs[r_s1_b];
    end
  end

  // S2: ALU; every result wraps to DATA_W bits.
  always_comb begin
    w_result = ZERO;
    w_err    = 1'b0;
    case (r_s1_opr)
      OP_ADD:  w_result = w_a + w_b;
      OP_SUB:  w_result = w_a - w_b;
      OP_MUL:  w_result = w_a * w_b;
      OP_PA:   w_result = w_a;
      OP_PB:   w_result = w_b;
      OP_AND:  w_result = w_a & w_b;
      OP_OR:   w_result = w_a | w_b;
      OP_XOR:  w_result = w_a ^ w_b;
      OP_NEGA: w_result = ZERO - w_a;
      OP_NEGB: w_result = ZERO - w_b;
      OP_SHR:  w_result = w_a >> 1'b1;
      OP_SHL:  w_result = w_a << 1'b1;
      OP_SLT:  w_result = (w_a < w_b) ? ONE : ZERO;
      OP_LDI:  w_result = r_s1_imm;
      default: begin
        w_result = ZERO;
        w_err    = 1'b1;
      end
    endcase
  end

  // S2 -> S3 latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= {RA_W{1'b0}};
      r_ex_maddr  <= {MA_W{1'b0}};
      r_ex_result <= ZERO;
      r_ex_err    <= 1'b0;
      r_ex_wr     <= 1'b0;
      r_ex_st     <= 1'b0;
    end else begin
      r_ex_valid  <= r_s1_valid;
      r_ex_rd     <= r_s1_rd;
      r_ex_maddr  <= r_s1_maddr;
      r_ex_result <= w_result;
      r_ex_err    <= w_err;
      r_ex_wr     <= r_s1_wr;
      r_ex_st     <= r_s1_st;
    end
  end

  // S3: register-file writeback; the whole file clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= ZERO;
      end
    end else if (w_wb_en) begin
      r_regs[r_ex_rd] <= r_ex_result;
    end
  end

  // S3: retire outputs; zout holds the last retired result between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zout      <= ZERO;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_out_valid <= r_ex_valid;
      r_out_err   <= r_ex_valid && r_ex_err;
      if (r_ex_valid) begin
        r_zout <= r_ex_result;
      end
    end
  end

  // S3 -> S4 latch; illegal instructions never reach memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_valid <= 1'b0;
      r_st_addr  <= {MA_W{1'b0}};
      r_st_data  <= ZERO;
    end else begin
      r_st_valid <= r_ex_valid && r_ex_st && !r_ex_err;
      r_st_addr  <= r_ex_maddr;
      r_st_data  <= r_ex_result;
    end
  end

  // S4: data memory write (memory contents survive reset).
  always_ff @(posedge clk) begin
    if (r_st_valid) begin
      r_mem[r_st_addr] <= r_st_data;
    end
  end

  // Debug read-back; a same-edge store is not visible until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbg_rdata <= ZERO;
    end else begin
      r_dbg_rdata <= r_mem[dbg_raddr];
    end
  end

  assign zout      = r_zout;
  assign out_valid = r_out_valid;
  assign out_err   = r_out_err;
  assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_alu_pipe_mem_store.sv
// Self-checking bench for alu_pipe_mem_store: issued instructions push their
// expected {err, result} into a queue; a monitor pops and compares on every
// out_valid. Scenario tasks add timing-specific inline checks.
module tb_alu_pipe_mem_store;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  opr;
  logic [3:0]  s1, s2, rd;
  logic [7:0]  maddr;
  logic [15:0] imm;
  logic        wr_en, st_en;
  logic [15:0] zout;
  logic        out_valid, out_err;
  logic [7:0]  dbg_raddr;
  logic [15:0] dbg_rdata;

  int errors = 0;
  int checks = 0;

  logic [16:0] sb_q[$];
  logic [15:0] m_regs [16];
  logic [15:0] m_mem  [256];
  logic [16:0] mon_exp;

  alu_pipe_mem_store #(.DATA_W(16), .RA_W(4), .MA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opr(opr),
    .s1(s1), .s2(s2), .rd(rd), .maddr(maddr), .imm(imm),
    .wr_en(wr_en), .st_en(st_en), .zout(zout), .out_valid(out_valid),
    .out_err(out_err), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model_op(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [15:0] im);
    logic [31:0] p;
    logic [16:0] r;
    p = {16'h0000, a} * {16'h0000, b};
    case (op)
      4'h0: r = {1'b0, 16'(a + b)};
      4'h1: r = {1'b0, 16'(a - b)};
      4'h2: r = {1'b0, p[15:0]};
      4'h3: r = {1'b0, a};
      4'h4: r = {1'b0, b};
      4'h5: r = {1'b0, a & b};
      4'h6: r = {1'b0, a | b};
      4'h7: r = {1'b0, a ^ b};
      4'h8: r = {1'b0, 16'(16'h0000 - a)};
      4'h9: r = {1'b0, 16'(16'h0000 - b)};
      4'hA: r = {2'b00, a[15:1]};
      4'hB: r = {1'b0, a[14:0], 1'b0};
      4'hC: r = (a < b) ? 17'h00001 : 17'h00000;
      4'hD: r = {1'b0, im};
      default: r = {1'b1, 16'h0000};
    endcase
    return r;
  endfunction

  // Scoreboard monitor: every retirement must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: out_valid with zout=%h err=%b, none expected", zout, out_err);
      end else begin
        mon_exp = sb_q.pop_front();
        if (zout !== mon_exp[15:0] || out_err !== mon_exp[16]) begin
          errors++;
          $display("FAIL scoreboard: got zout=%h err=%b, expected zout=%h err=%b",
                   zout, out_err, mon_exp[15:0], mon_exp[16]);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [7:0] ma, input logic [15:0] im,
                       input logic w, input logic st);
    in_valid = 1'b1; opr = op; s1 = a; s2 = b; rd = d;
    maddr = ma; imm = im; wr_en = w; st_en = st;
  endtask

  // Drive one instruction for one edge and record its expected outcome.
  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [7:0] ma, input logic [15:0] im,
                       input logic w, input logic st);
    logic [16:0] e;
    e = model_op(op, m_regs[a], m_regs[b], im);
    drive(op, a, b, d, ma, im, w, st);
    sb_q.push_back(e);
    if (!e[16]) begin
      if (w)  m_regs[d] = e[15:0];
      if (st) m_mem[ma] = e[15:0];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; wr_en = 1'b0; st_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (zout !== 16'h0000 || out_valid !== 1'b0 || out_err !== 1'b0 || dbg_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: zout=%h valid=%b err=%b dbg=%h, expected all 0",
               zout, out_valid, out_err, dbg_rdata);
    end
    rst_n = 1'b1;
    // Build up a visible result, then reset asynchronously mid-stream.
    issue(4'hD, 4'd0, 4'd0, 4'd2, 8'h00, 16'h5555, 1'b1, 1'b0);
    issue(4'hD, 4'd0, 4'd0, 4'd3, 8'h00, 16'h5555, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || zout !== 16'h5555) begin
      errors++;
      $display("FAIL pre_reset_out: valid=%b zout=%h, expected 1 5555", out_valid, zout);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (zout !== 16'h0000 || out_valid !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: zout=%h valid=%b err=%b, expected 0 0 0", zout, out_valid, out_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Accepted in the first cycle after release; registers read back as 0.
    issue(4'h0, 4'd1, 4'd2, 4'd3, 8'h00, 16'h0000, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (out_valid !== 1'b1 || zout !== 16'h0000) begin
      errors++;
      $display("FAIL post_reset_add: valid=%b zout=%h, expected 1 0000", out_valid, zout);
    end
    idle(2);
  endtask

  task automatic test_chain();
    issue(4'hD, 4'd0, 4'd0, 4'd1, 8'h00, 16'h0005, 1'b1, 1'b0);
    issue(4'hD, 4'd0, 4'd0, 4'd2, 8'h00, 16'h0003, 1'b1, 1'b0);
    issue(4'h0, 4'd1, 4'd2, 4'd3, 8'h00, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || zout !== 16'h0005) begin
      errors++;
      $display("FAIL chain_k2: valid=%b zout=%h, expected 1 0005", out_valid, zout);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || zout !== 16'h0003) begin
      errors++;
      $display("FAIL chain_k3: valid=%b zout=%h, expected 1 0003", out_valid, zout);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || zout !== 16'h0008) begin
      errors++;
      $display("FAIL chain_k4: valid=%b zout=%h, expected 1 0008", out_valid, zout);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL chain_pulse: valid=%b, expected 0", out_valid);
    end
    idle(2);
  endtask

  task automatic test_wrap();
    issue(4'hD, 4'd0, 4'd0, 4'd1, 8'h00, 16'h0100, 1'b1, 1'b0);
    issue(4'hD, 4'd0, 4'd0, 4'd2, 8'h00, 16'h0100, 1'b1, 1'b0);
    issue(4'h2, 4'd1, 4'd2, 4'd3, 8'h00, 16'h0000, 1'b1, 1'b0);  // 0x0000
    issue(4'hD, 4'd0, 4'd0, 4'd4, 8'h00, 16'h0000, 1'b1, 1'b0);
    issue(4'hD, 4'd0, 4'd0, 4'd5, 8'h00, 16'h0001, 1'b1, 1'b0);
    issue(4'h1, 4'd4, 4'd5, 4'd6, 8'h00, 16'h0000, 1'b1, 1'b0);  // 0xFFFF
    issue(4'h8, 4'd5, 4'd0, 4'd7, 8'h00, 16'h0000, 1'b1, 1'b0);  // 0xFFFF
    issue(4'hD, 4'd0, 4'd0, 4'd8, 8'h00, 16'h0002, 1'b1, 1'b0);
    issue(4'hD, 4'd0, 4'd0, 4'd9, 8'h00, 16'h0003, 1'b1, 1'b0);
    issue(4'hC, 4'd8, 4'd9, 4'd10, 8'h00, 16'h0000, 1'b1, 1'b0); // 1
    idle(4);
  endtask

  task automatic test_ops();
    logic [15:0] v1, v2;
    v1 = 16'($urandom);
    v2 = 16'($urandom) | 16'h8001;
    issue(4'hD, 4'd0, 4'd0, 4'd11, 8'h00, v1, 1'b1, 1'b0);
    issue(4'hD, 4'd0, 4'd0, 4'd12, 8'h00, v2, 1'b1, 1'b0);
    for (int op = 0; op < 13; op++) begin
      issue(4'(op), (op % 2 == 1) ? 4'd13 : 4'd11, 4'd12, 4'd13, 8'h00, 16'h0000, 1'b1, 1'b0);
    end
    issue(4'h9, 4'd0, 4'd13, 4'd14, 8'h00, 16'h0000, 1'b1, 1'b0);
    idle(4);
  endtask

  task automatic test_illegal();
    issue(4'hD, 4'd0, 4'd0, 4'd1, 8'h20, 16'h0042, 1'b1, 1'b1);
    issue(4'hF, 4'd1, 4'd1, 4'd1, 8'h20, 16'h1234, 1'b1, 1'b1);
    idle(2);
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || zout !== 16'h0000) begin
      errors++;
      $display("FAIL illegal_out: valid=%b err=%b zout=%h, expected 1 1 0000", out_valid, out_err, zout);
    end
    issue(4'hE, 4'd1, 4'd1, 4'd1, 8'h20, 16'h4321, 1'b1, 1'b1);
    issue(4'h3, 4'd1, 4'd0, 4'd2, 8'h00, 16'h0000, 1'b1, 1'b0);  // old 0x0042
    idle(5);
    dbg_raddr = 8'h20;
    @(negedge clk);
    checks++;
    if (dbg_rdata !== 16'h0042) begin
      errors++;
      $display("FAIL illegal_mem: dbg_rdata=%h, expected 0042", dbg_rdata);
    end
  endtask

  task automatic test_store();
    logic [15:0] old_v;
    issue(4'hD, 4'd0, 4'd0, 4'd4, 8'h10, 16'h1234, 1'b0, 1'b1);
    idle(4);
    old_v = m_mem[8'h10];
    dbg_raddr = 8'h10;
    issue(4'hD, 4'd0, 4'd0, 4'd1, 8'h00, 16'h0005, 1'b1, 1'b0);
    issue(4'hD, 4'd0, 4'd0, 4'd2, 8'h00, 16'h0003, 1'b1, 1'b0);
    issue(4'h0, 4'd1, 4'd2, 4'd3, 8'h10, 16'h0000, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (dbg_rdata !== old_v || old_v !== 16'h1234) begin
      errors++;
      $display("FAIL store_same_edge: dbg_rdata=%h, expected old %h", dbg_rdata, old_v);
    end
    idle(1);
    checks++;
    if (dbg_rdata !== 16'h0008) begin
      errors++;
      $display("FAIL store_readback: dbg_rdata=%h, expected 0008", dbg_rdata);
    end
    idle(1);
  endtask

  task automatic test_midflight();
    issue(4'hD, 4'd0, 4'd0, 4'd5, 8'h30, 16'h1111, 1'b1, 1'b1);
    issue(4'hD, 4'd0, 4'd0, 4'd6, 8'h31, 16'h1111, 1'b1, 1'b1);
    issue(4'hD, 4'd0, 4'd0, 4'd7, 8'h32, 16'h1111, 1'b1, 1'b1);
    idle(5);
    drive(4'hD, 4'd0, 4'd0, 4'd5, 8'h30, 16'hAAAA, 1'b1, 1'b1);
    @(negedge clk);
    drive(4'hD, 4'd0, 4'd0, 4'd6, 8'h31, 16'hAAAA, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    drive(4'hD, 4'd0, 4'd0, 4'd7, 8'h32, 16'hAAAA, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_valid[%0d]: out_valid=%b, expected 0", i, out_valid);
      end
    end
    for (int i = 0; i < 3; i++) begin
      dbg_raddr = 8'(8'h30 + i);
      @(negedge clk);
      checks++;
      if (dbg_rdata !== m_mem[8'(8'h30 + i)]) begin
        errors++;
        $display("FAIL midflight_mem[%0d]: dbg_rdata=%h, expected %h", i, dbg_rdata, m_mem[8'(8'h30 + i)]);
      end
    end
    issue(4'h3, 4'd5, 4'd0, 4'd0, 8'h00, 16'h0000, 1'b0, 1'b0);
    issue(4'h3, 4'd6, 4'd0, 4'd0, 8'h00, 16'h0000, 1'b0, 1'b0);
    idle(4);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opr = 4'h0; s1 = 4'h0; s2 = 4'h0; rd = 4'h0;
    maddr = 8'h00; imm = 16'h0000; wr_en = 1'b0; st_en = 1'b0; dbg_raddr = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    test_reset();
    test_chain();
    test_wrap();
    test_ops();
    test_illegal();
    test_store();
    test_midflight();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results missing, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
